raster_to_block: RTL and testbench

Upstream feeder for `stego_encode`. It accepts a raster-order 8-bit luma pixel stream and buffers eight lines at a time in a ping-pong band memory. It re-emits each band as contiguous 64-sample 8x8 blocks (row-major inside each block, blocks left to right), driving the encoder's `data_in`/`start`. It also serialises message bytes into the per-block `message` bit that the encoder samples on the first sample of each block.

---
 rtl/stego_pkg.sv | 14 +
 rtl/r2b_band_ram.sv | 38 +++
 rtl/raster_to_block.sv | 234 +++++++++++++++++++++++
 tb/tb_raster_to_block.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stego_pkg.sv
// Shared block geometry, pixel type and read-FSM state encoding for the stego front end.
package stego_pkg;

  localparam int BLK_N  = 8;
  localparam int BLK_SZ = 64;

  typedef logic [7:0] pix_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/r2b_band_ram.sv
// Simple dual-port band RAM: one write port, one read port with a registered output.
module r2b_band_ram
  import stego_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  pix_t mem_q [DEPTH];
  pix_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Only the output register is reset (rst_i is active low); the array keeps its contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/raster_to_block.sv
// Raster-to-8x8-block converter with ping-pong band buffer and per-block message bit.
// Define RASTER_TO_BLOCK_MSG_EN to include the message byte serialiser.
module raster_to_block
  import stego_pkg::*;
#(
  parameter int IMG_W = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_vld,
  input  logic       sof,
  output logic [7:0] data_out,
  output logic       start,
  output logic       message,
  input  logic [7:0] msg_byte,
  input  logic       msg_vld,
  output logic       msg_rdy,
  output logic       busy,
  output logic       err_sync
);

  localparam int BANK_SZ = BLK_N * IMG_W;
  localparam int DEPTH   = 2 * BANK_SZ;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = $clog2(IMG_W);
  localparam int NBLK    = IMG_W / BLK_N;
  localparam int BW      = (NBLK > 1) ? $clog2(NBLK) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(NBLK - 1);
  localparam logic [2:0]    IDX_LAST = 3'(BLK_N - 1);

  logic          started_q, started_d;
  logic [CW-1:0] wcol_q, wcol_d;
  logic [2:0]    wrow_q, wrow_d;
  logic          wbank_q, wbank_d;
  logic          err_q, err_d;
  logic          req_q, req_d;
  logic          req_bank_q, req_bank_d;
  logic          req_set;
  logic          accept;
  logic [AW-1:0] waddr;

  rd_state_e     state_q, state_d;
  logic [2:0]    col_q, col_d;
  logic [2:0]    row_q, row_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          rbank_q, rbank_d;
  logic          start_q;
  logic          rd_en;
  logic          last_addr;
  logic          first_blk;
  logic [AW-1:0] raddr;

  // Pixels are ignored until the first sof after reset; a sof pixel always lands at band offset 0.
  assign accept = pix_vld && (sof || started_q);
  assign waddr  = AW'(int'(wbank_q) * BANK_SZ
                      + (sof ? 0 : (int'(wrow_q) * IMG_W + int'(wcol_q))));

  always_comb begin
    started_d = started_q;
    wcol_d    = wcol_q;
    wrow_d    = wrow_q;
    wbank_d   = wbank_q;
    err_d     = err_q;
    req_set   = 1'b0;
    if (accept) begin
      if (sof) begin
        started_d = 1'b1;
        if ((wcol_q != '0) || (wrow_q != '0)) begin
          err_d = 1'b1;
        end
        wcol_d = CW'(1);
        wrow_d = '0;
      end else if (wcol_q == COL_LAST) begin
        wcol_d = '0;
        if (wrow_q == IDX_LAST) begin
          wrow_d  = '0;
          wbank_d = ~wbank_q;
          req_set = 1'b1;
        end else begin
          wrow_d = wrow_q + 3'd1;
        end
      end else begin
        wcol_d = wcol_q + CW'(1);
      end
    end
  end

  assign rd_en     = (state_q == READ);
  assign last_addr = rd_en && (col_q == IDX_LAST) && (row_q == IDX_LAST) && (blk_q == BLK_LAST);
  assign first_blk = rd_en && (col_q == '0) && (row_q == '0);
  assign raddr     = AW'(int'(rbank_q) * BANK_SZ + int'(row_q) * IMG_W
                         + int'(blk_q) * BLK_N + int'(col_q));

  // A request pending at the last address chains straight into the next band with no idle cycle.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    blk_d      = blk_q;
    rbank_d    = rbank_q;
    req_d      = req_q;
    req_bank_d = req_bank_q;
    case (state_q)
      IDLE: begin
        if (req_q) begin
          state_d = READ;
          rbank_d = req_bank_q;
          req_d   = 1'b0;
        end
      end
      READ: begin
        col_d = col_q + 3'd1;
        if (col_q == IDX_LAST) begin
          row_d = row_q + 3'd1;
          if (row_q == IDX_LAST) begin
            blk_d = (blk_q == BLK_LAST) ? '0 : blk_q + BW'(1);
          end
        end
        if (last_addr) begin
          if (req_q) begin
            rbank_d = req_bank_q;
            req_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (req_set) begin
      req_d      = 1'b1;
      req_bank_d = wbank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      started_q  <= 1'b0;
      wcol_q     <= '0;
      wrow_q     <= '0;
      wbank_q    <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      req_bank_q <= 1'b0;
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      blk_q      <= '0;
      rbank_q    <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      started_q  <= started_d;
      wcol_q     <= wcol_d;
      wrow_q     <= wrow_d;
      wbank_q    <= wbank_d;
      err_q      <= err_d;
      req_q      <= req_d;
      req_bank_q <= req_bank_d;
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      blk_q      <= blk_d;
      rbank_q    <= rbank_d;
      start_q    <= rd_en;
    end
  end

  r2b_band_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (accept),
    .waddr_i(waddr),
    .wdata_i(pix_in),
    .re_i   (rd_en),
    .raddr_i(raddr),
    .rdata_o(data_out)
  );

  assign start    = start_q;
  assign busy     = rd_en;
  assign err_sync = err_q;

`ifdef RASTER_TO_BLOCK_MSG_EN
  logic [7:0] sh_q, sh_d;
  logic [3:0] cnt_q, cnt_d;
  logic       msg_q, msg_d;

  // Loads only happen when empty, so a load and a block-start consume never both shift the register.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    msg_d = msg_q;
    if (msg_vld && (cnt_q == 4'd0)) begin
      sh_d  = msg_byte;
      cnt_d = 4'd8;
    end
    if (first_blk) begin
      if (cnt_q != 4'd0) begin
        msg_d = sh_q[0];
        sh_d  = {1'b0, sh_q[7:1]};
        cnt_d = cnt_q - 4'd1;
      end else begin
        msg_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
      msg_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      msg_q <= msg_d;
    end
  end

  assign message = msg_q;
  assign msg_rdy = (cnt_q == 4'd0);
`else
  logic unused_msg;
  assign unused_msg = ^{msg_byte, msg_vld, first_blk};
  assign message    = 1'b0;
  assign msg_rdy    = 1'b0;
`endif

endmodule

// File: tb/tb_raster_to_block.sv
// Self-checking bench for raster_to_block (IMG_W=16): block-order scoreboard, vector tables, corner sequences.
module tb_raster_to_block;

  localparam int W    = 16;
  localparam int BAND = 8 * W;
`ifdef RASTER_TO_BLOCK_MSG_EN
  localparam bit MSG_EN = 1'b1;
`else
  localparam bit MSG_EN = 1'b0;
`endif
  localparam logic [9:0] MSG_BITS = MSG_EN ? 10'h0A5 : 10'h000;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic [7:0] pix_in   = '0;
  logic       pix_vld  = 1'b0;
  logic       sof      = 1'b0;
  logic [7:0] msg_byte = '0;
  logic       msg_vld  = 1'b0;
  logic [7:0] data_out;
  logic       start, message, msg_rdy, busy, err_sync;

  raster_to_block #(.IMG_W(W)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_vld(pix_vld), .sof(sof),
    .data_out(data_out), .start(start), .message(message),
    .msg_byte(msg_byte), .msg_vld(msg_vld), .msg_rdy(msg_rdy),
    .busy(busy), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; int cycNum; logic msg; logic rdy; } capT;
  typedef struct { int idx; logic [7:0] expData; } frameVecT;
  typedef struct { int blockIdx; logic expMsg; logic expRdy; } msgVecT;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         busyCount = 0;
  int         sampleCount = 0;
  int         lastBandCyc = 0;
  logic [7:0] pixQ[$];
  logic [7:0] expQ[$];
  logic       msgQ[$];
  logic       started = 1'b0;
  logic       errExp = 1'b0;
  capT        cap[$];
  frameVecT   frameVec[9];
  msgVecT     msgVec[10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Monitor: every start cycle is scored against the reference band queue; block starts also check the message.
  always @(negedge clk) begin
    logic [7:0] expD;
    logic       expM, expR;
    if (!rst) begin
      sampleCount = 0;
    end else begin
      if (busy === 1'b1) busyCount++;
      if (start === 1'b1) begin
        cap.push_back('{data_out, cyc, message, msg_rdy});
        if (expQ.size() == 0) begin
          checkOutput("unexpected_start", 1, 0);
        end else begin
          expD = expQ.pop_front();
          checkOutput("sample_data", data_out, expD);
          if (sampleCount % 64 == 0) begin
            expM = (msgQ.size() != 0) ? msgQ.pop_front() : 1'b0;
            expR = MSG_EN && (msgQ.size() == 0);
            checkOutput("block_message", message, expM);
            checkOutput("block_msg_rdy", msg_rdy, expR);
          end
          sampleCount++;
        end
      end
    end
  end

  // Drives one pixel for one cycle and updates the reference: a full band is queued in block order.
  task automatic applyStimulus(input logic [7:0] p, input logic s);
    @(posedge clk); #1;
    pix_in = p; pix_vld = 1'b1; sof = s;
    if (s) begin
      if (pixQ.size() != 0) errExp = 1'b1;
      pixQ.delete();
      started = 1'b1;
    end
    if (started) begin
      pixQ.push_back(p);
      if (pixQ.size() == BAND) begin
        for (int b = 0; b < W / 8; b++)
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
              expQ.push_back(pixQ[r * W + b * 8 + c]);
        pixQ.delete();
        lastBandCyc = cyc;
      end
    end
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
    pix_vld = 1'b0; sof = 1'b0;
  endtask

  task automatic applyFrame(input int nBands);
    for (int r = 0; r < nBands * 8; r++)
      for (int c = 0; c < W; c++)
        applyStimulus(8'((r * W + c) % 256), (r == 0) && (c == 0));
    idleCycle();
  endtask

  task automatic randFrame(input int nBands, input int abortAt);
    if (abortAt > 0) begin
      for (int i = 0; i < abortAt; i++) applyStimulus(8'($urandom), i == 0);
    end
    for (int i = 0; i < nBands * BAND; i++) begin
      if ($urandom_range(0, 3) == 0) idleCycle();
      applyStimulus(8'($urandom), i == 0);
    end
    idleCycle();
  endtask

  task automatic sendByte(input logic [7:0] b);
    checkOutput("msg_rdy_before_load", msg_rdy, MSG_EN);
    @(posedge clk); #1;
    msg_byte = b; msg_vld = 1'b1;
    if (MSG_EN) for (int i = 0; i < 8; i++) msgQ.push_back(b[i]);
    @(posedge clk); #1;
    msg_vld = 1'b0;
    @(negedge clk);
    checkOutput("msg_rdy_after_load", msg_rdy, 0);
  endtask

  task automatic waitDrain();
    bit done = 1'b0;
    @(posedge clk); #1;
    pix_vld = 1'b0; sof = 1'b0; msg_vld = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && busy !== 1'b1 && start !== 1'b1) done = 1'b1;
    end
    if (!done) checkOutput("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    rst = 1'b0; pix_vld = 1'b0; sof = 1'b0; msg_vld = 1'b0;
    pixQ.delete(); expQ.delete(); msgQ.delete();
    started = 1'b0; errExp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_data_out", data_out, 0);
    checkOutput("rst_message", message, 0);
    checkOutput("rst_msg_rdy", msg_rdy, MSG_EN);
    checkOutput("rst_err_sync", err_sync, 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic checkFrameTable(input string tag);
    logic [7:0] got;
    checkOutput({tag, "_count"}, cap.size(), BAND);
    for (int i = 0; i < 9; i++) begin
      got = (frameVec[i].idx < cap.size()) ? cap[frameVec[i].idx].data : 8'hxx;
      checkOutput($sformatf("%s_sample%0d", tag, frameVec[i].idx), got, frameVec[i].expData);
    end
  endtask

  function automatic int countBreaks();
    int n = 0;
    for (int i = 1; i < cap.size(); i++)
      if (cap[i].cycNum != cap[i - 1].cycNum + 1) n++;
    return n;
  endfunction

  initial begin
    int bandCyc;
    bit seen;
    logic [31:0] got;

    frameVec[0] = '{0, 8'd0};    frameVec[1] = '{1, 8'd1};
    frameVec[2] = '{7, 8'd7};    frameVec[3] = '{8, 8'd16};
    frameVec[4] = '{63, 8'd119}; frameVec[5] = '{64, 8'd8};
    frameVec[6] = '{71, 8'd15};  frameVec[7] = '{72, 8'd24};
    frameVec[8] = '{127, 8'd127};
    for (int k = 0; k < 10; k++) msgVec[k] = '{k, MSG_BITS[k], MSG_EN && (k >= 7)};

    applyReset();

    // Pixels before any sof must never produce output.
    cap.delete(); busyCount = 0;
    for (int i = 0; i < 150; i++) applyStimulus(8'($urandom), 1'b0);
    waitDrain();
    repeat (20) @(negedge clk);
    checkOutput("pre_sof_starts", cap.size(), 0);
    checkOutput("pre_sof_busy", busyCount, 0);

    // One band at full rate: latency, ordering, contiguity.
    cap.delete(); busyCount = 0;
    applyFrame(1);
    bandCyc = lastBandCyc;
    waitDrain();
    checkFrameTable("frame1");
    checkOutput("first_start_latency", (cap.size() > 0) ? cap[0].cycNum : -1, bandCyc + 3);
    checkOutput("frame1_contiguous", countBreaks(), 0);
    checkOutput("frame1_busy_cycles", busyCount, BAND);
    checkOutput("frame1_err_sync", err_sync, 0);

    // Two bands back to back: the second read chains with no gap.
    cap.delete(); busyCount = 0;
    applyFrame(2);
    waitDrain();
    checkOutput("two_band_count", cap.size(), 2 * BAND);
    checkOutput("two_band_contiguous", countBreaks(), 0);
    checkOutput("two_band_busy_cycles", busyCount, 2 * BAND);
    checkOutput("two_band_s128", (cap.size() > 128) ? cap[128].data : 32'hffff, 128);
    checkOutput("two_band_s255", (cap.size() > 255) ? cap[255].data : 32'hffff, 255);

    // Message byte 0xA5 spread over ten blocks.
    cap.delete();
    sendByte(8'hA5);
    applyFrame(5);
    waitDrain();
    checkOutput("msg_frame_count", cap.size(), 5 * BAND);
    for (int k = 0; k < 10; k++) begin
      got = (64 * k < cap.size()) ? cap[64 * k].msg : 32'hffff;
      checkOutput($sformatf("msg_block%0d", msgVec[k].blockIdx), got, msgVec[k].expMsg);
      got = (64 * k < cap.size()) ? cap[64 * k].rdy : 32'hffff;
      checkOutput($sformatf("msg_rdy_block%0d", msgVec[k].blockIdx), got, msgVec[k].expRdy);
    end

    // sof in the middle of row 3 discards the partial band.
    cap.delete();
    applyStimulus(8'd200, 1'b1);
    for (int i = 0; i < 3 * W + 4; i++) applyStimulus(8'(i + 60), 1'b0);
    applyFrame(1);
    waitDrain();
    checkOutput("mid_sof_err_sync", err_sync, errExp);
    checkFrameTable("mid_sof");

    // Reset in the middle of a band read, then a fresh frame.
    cap.delete();
    applyFrame(1);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (cap.size() >= 20) seen = 1'b1;
    end
    checkOutput("mid_read_reached", seen, 1);
    applyReset();
    cap.delete();
    applyFrame(1);
    waitDrain();
    checkFrameTable("post_reset");

    // Randomised frames with gaps, occasional aborted bands and message bytes.
    for (int it = 0; it < 6; it++) begin
      waitDrain();
      if (MSG_EN && msgQ.size() == 0) sendByte(8'($urandom));
      randFrame($urandom_range(1, 2), (it == 3) ? 37 : 0);
    end
    waitDrain();
    checkOutput("final_err_sync", err_sync, errExp);
    checkOutput("final_queue_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
